// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - multi-channel idle clock gating controller with wake handshake
module clk_gate_ctrl #(
  parameter int ch       = 2,
  parameter int idle_cyc = 4,
  parameter int wake_cyc = 2,
  parameter int cnt_bw   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ch-1:0]        busy,
  input  logic [ch-1:0]        wake_req,
  input  logic                 te,
  input  logic                 clr_cnt,
  output logic [ch-1:0]        gclk,
  output logic [ch-1:0]        clk_en,
  output logic [ch-1:0]        ready,
  output logic [ch*cnt_bw-1:0] gated_cyc
);

  localparam int iw = $clog2(idle_cyc + 1);
  localparam int ww = $clog2(wake_cyc + 1);

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } state_t;

  state_t            state_q [ch];
  state_t            state_d [ch];
  logic [iw-1:0]     idle_q  [ch];
  logic [iw-1:0]     idle_d  [ch];
  logic [ww-1:0]     wake_q  [ch];
  logic [ww-1:0]     wake_d  [ch];
  logic [cnt_bw-1:0] cnt_q   [ch];
  logic [ch-1:0]     act;
  logic [ch-1:0]     gate_q;

  assign act = busy | wake_req;

  // Per-channel FSM state and idle/wake counters; reset forces every channel on.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ch; i++) begin
      if (reset) begin
        state_q[i] <= ST_ON;
        idle_q[i]  <= '0;
        wake_q[i]  <= '0;
      end else begin
        state_q[i] <= state_d[i];
        idle_q[i]  <= idle_d[i];
        wake_q[i]  <= wake_d[i];
      end
    end
  end

  // Next-state logic; clk_en and ready decode straight from the state register.
  always_comb begin
    clk_en = '0;
    ready  = '0;
    for (int i = 0; i < ch; i++) begin
      state_d[i] = state_q[i];
      idle_d[i]  = idle_q[i];
      wake_d[i]  = wake_q[i];
      clk_en[i]  = (state_q[i] != ST_OFF);
      ready[i]   = (state_q[i] == ST_ON);
      case (state_q[i])
        ST_ON: begin
          if (act[i]) begin
            idle_d[i] = '0;
          end else if (idle_q[i] == iw'(idle_cyc - 1)) begin
            state_d[i] = ST_OFF;
            idle_d[i]  = '0;
          end else begin
            idle_d[i] = idle_q[i] + iw'(1);
          end
        end
        ST_OFF: begin
          if (act[i]) begin
            state_d[i] = ST_WAKE;
            wake_d[i]  = '0;
          end
        end
        ST_WAKE: begin
          // Activity is deliberately ignored here: a waking channel always completes its wake.
          if (wake_q[i] == ww'(wake_cyc - 1)) begin
            state_d[i] = ST_ON;
            wake_d[i]  = '0;
            idle_d[i]  = '0;
          end else begin
            wake_d[i] = wake_q[i] + ww'(1);
          end
        end
        default: begin
          state_d[i] = ST_ON;
        end
      endcase
    end
  end

  // Saturating count of suppressed cycles; clear beats increment, test mode freezes it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ch; i++) begin
      if (reset || clr_cnt) begin
        cnt_q[i] <= '0;
      end else if ((state_q[i] == ST_OFF) && !te && (cnt_q[i] != {cnt_bw{1'b1}})) begin
        cnt_q[i] <= cnt_q[i] + cnt_bw'(1);
      end
    end
  end

  // Low-transparent enable latch: enable only moves while clk is low, so gclk never slivers.
  always_latch begin
    if (!clk) begin
      gate_q <= clk_en | {ch{te}};
    end
  end

  assign gclk = {ch{clk}} & gate_q;

  for (genvar g = 0; g < ch; g++) begin : g_cnt_out
    assign gated_cyc[g*cnt_bw +: cnt_bw] = cnt_q[g];
  end

endmodule
